cmu_assoc: RTL and testbench

Parametrised successor of the direct-mapped cache management unit. It is a 2-way set-associative, write-back, write-allocate cache controller with internal tag, valid, dirty, LRU and data arrays. It sits between the CPU data port and the word-wide RAM port, which uses a cs/we/ack handshake. It refills and writes back whole lines one word per ack, and exposes access/miss performance counters.

---
 rtl/cmu_assoc.sv | 212 +++++++++++++++++++++
 tb/tb_cmu_assoc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmu_assoc.sv
// Two-way set-associative, write-back, write-allocate cache controller between
// the CPU word port and a word-wide cs/we/ack RAM port, with perf counters.
module cmu_assoc #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_WORDS_WIDTH = 2,
  parameter int SET_WIDTH        = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  stall,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  input  logic                  ram_ack,
  output logic [CNT_WIDTH-1:0]  acc_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int TAG_BITS = ADDR_WIDTH - SET_WIDTH - LINE_WORDS_WIDTH - 2;
  localparam int SETS     = 1 << SET_WIDTH;
  localparam int WORDS    = 1 << LINE_WORDS_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BACK = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]          r_data [2][SETS][WORDS];
  logic [TAG_BITS-1:0]  r_tags [2][SETS];
  logic [1:0][SETS-1:0] r_valid;
  logic [1:0][SETS-1:0] r_dirty;
  logic [SETS-1:0]      r_lru;

  // Context of the miss being serviced; the CPU may drop cs mid-refill.
  logic                        r_vic_way;
  logic [TAG_BITS-1:0]         r_vic_tag;
  logic [TAG_BITS-1:0]         r_miss_tag;
  logic [SET_WIDTH-1:0]        r_miss_index;
  logic [LINE_WORDS_WIDTH-1:0] r_cnt;

  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [31:0]           r_ram_din;
  logic [CNT_WIDTH-1:0]  r_acc_count;
  logic [CNT_WIDTH-1:0]  r_miss_count;

  logic [TAG_BITS-1:0]         w_tag;
  logic [SET_WIDTH-1:0]        w_index;
  logic [LINE_WORDS_WIDTH-1:0] w_word;
  logic                        w_hit0;
  logic                        w_hit1;
  logic                        w_hit;
  logic                        w_hit_way;
  logic                        w_victim;
  logic                        w_victim_dirty;
  logic                        w_idle;
  logic                        w_idle_hit;
  logic                        w_miss;
  logic                        w_ack;
  logic                        w_last;
  logic [LINE_WORDS_WIDTH-1:0] w_cnt_next;
  logic                        w_unused_addr;

  assign w_tag         = addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_index       = addr[2+LINE_WORDS_WIDTH +: SET_WIDTH];
  assign w_word        = addr[2 +: LINE_WORDS_WIDTH];
  assign w_unused_addr = ^addr[1:0];

  assign w_hit0    = r_valid[0][w_index] && (r_tags[0][w_index] == w_tag);
  assign w_hit1    = r_valid[1][w_index] && (r_tags[1][w_index] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1;

  // Prefer an empty way; only a full set consults the LRU bit.
  assign w_victim = !r_valid[0][w_index] ? 1'b0 :
                    !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
  assign w_victim_dirty = r_valid[w_victim][w_index] && r_dirty[w_victim][w_index];

  assign w_idle     = (r_state == S_IDLE);
  assign w_idle_hit = w_idle && cs && w_hit;
  assign w_miss     = w_idle && cs && !w_hit;
  assign w_ack      = ram_ack && r_ram_cs;
  assign w_last     = (r_cnt == '1);
  assign w_cnt_next = r_cnt + LINE_WORDS_WIDTH'(1);

  assign stall = !w_idle || (cs && !w_hit);
  assign dout  = w_idle_hit ? r_data[w_hit_way][w_index][w_word] : 32'h0;

  assign ram_cs     = r_ram_cs;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign acc_count  = r_acc_count;
  assign miss_count = r_miss_count;

  always_comb begin
    // NOTE: default first so no path through the case leaves the target unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_miss) w_next_state = w_victim_dirty ? S_BACK : S_FILL;
      S_BACK: if (w_ack && w_last) w_next_state = S_FILL;
      S_FILL: if (w_ack && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_dirty      <= '0;
      r_lru        <= '0;
      r_cnt        <= '0;
      r_vic_way    <= 1'b0;
      r_vic_tag    <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_ram_cs     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_acc_count  <= '0;
      r_miss_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_idle_hit) begin
            r_lru[w_index] <= !w_hit_way;
            if (we) r_dirty[w_hit_way][w_index] <= 1'b1;
            if (r_acc_count != '1) r_acc_count <= r_acc_count + CNT_WIDTH'(1);
          end else if (w_miss) begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_WIDTH'(1);
            r_vic_way    <= w_victim;
            r_vic_tag    <= r_tags[w_victim][w_index];
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
            r_cnt        <= '0;
            r_ram_cs     <= 1'b1;
            if (w_victim_dirty) begin
              r_ram_we   <= 1'b1;
              r_ram_addr <= {r_tags[w_victim][w_index], w_index, {LINE_WORDS_WIDTH{1'b0}}, 2'b00};
              r_ram_din  <= r_data[w_victim][w_index][0];
            end else begin
              r_ram_we   <= 1'b0;
              r_ram_addr <= {w_tag, w_index, {LINE_WORDS_WIDTH{1'b0}}, 2'b00};
              r_ram_din  <= '0;
            end
          end
        end
        S_BACK: begin
          if (w_ack) begin
            if (w_last) begin
              r_cnt      <= '0;
              r_ram_we   <= 1'b0;
              r_ram_addr <= {r_miss_tag, r_miss_index, {LINE_WORDS_WIDTH{1'b0}}, 2'b00};
              r_ram_din  <= '0;
            end else begin
              r_cnt      <= w_cnt_next;
              r_ram_addr <= {r_vic_tag, r_miss_index, w_cnt_next, 2'b00};
              r_ram_din  <= r_data[r_vic_way][r_miss_index][w_cnt_next];
            end
          end
        end
        S_FILL: begin
          if (w_ack) begin
            if (w_last) begin
              r_cnt                          <= '0;
              r_valid[r_vic_way][r_miss_index] <= 1'b1;
              r_dirty[r_vic_way][r_miss_index] <= 1'b0;
              r_ram_cs                       <= 1'b0;
              r_ram_we                       <= 1'b0;
              r_ram_addr                     <= '0;
              r_ram_din                      <= '0;
            end else begin
              r_cnt      <= w_cnt_next;
              r_ram_addr <= {r_miss_tag, r_miss_index, w_cnt_next, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_idle_hit && we) r_data[w_hit_way][w_index][w_word] <= din;
    if ((r_state == S_FILL) && w_ack) begin
      r_data[r_vic_way][r_miss_index][r_cnt] <= ram_dout;
      if (w_last) r_tags[r_vic_way][r_miss_index] <= r_miss_tag;
    end
  end

endmodule

// File: tb/tb_cmu_assoc.sv
// Self-checking bench for cmu_assoc: directed scenarios plus random traffic
// compared against a recency-list cache model and a flat memory image.
module tb_cmu_assoc;

  typedef struct packed {
    logic [23:0]      tag;
    logic             dirty;
    logic [3:0][31:0] data;
  } line_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } log_t;

  logic        clk = 1'b0;
  logic        rst_n, cs, we;
  logic [31:0] addr, din, dout;
  logic        stall;
  logic        ram_cs, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [31:0] acc_count, miss_count;

  int total = 0;
  int bad   = 0;

  cmu_assoc dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .stall(stall), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ack(ram_ack), .acc_count(acc_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- RAM responder ----------------
  logic [31:0] ram_mem [logic [31:0]];
  log_t        dut_log [$];
  int          ram_wait = 0;
  int          wcnt = 0;
  bit          pend = 0;
  logic [31:0] held_addr, held_din;
  logic        held_we;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !ram_cs) begin
      ram_ack = 1'b0;
      wcnt    = 0;
      pend    = 0;
    end else begin
      if (pend) begin
        check("hold_addr", ram_addr, held_addr);
        check("hold_din", ram_din, held_din);
        check("hold_we", {31'h0, ram_we}, {31'h0, held_we});
      end
      if (wcnt >= ram_wait) begin
        ram_ack = 1'b1;
        dut_log.push_back(log_t'({ram_we, ram_addr, ram_we ? ram_din : 32'h0}));
        if (ram_we) ram_mem[ram_addr] = ram_din;
        else        ram_dout = ram_rd(ram_addr);
        wcnt = 0;
        pend = 0;
      end else begin
        ram_ack = 1'b0;
        if (!pend) begin
          held_addr = ram_addr;
          held_din  = ram_din;
          held_we   = ram_we;
        end
        pend = 1;
        wcnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  line_t       sets [16][$];
  logic [31:0] exp_mem [logic [31:0]];
  log_t        exp_log [$];
  int          exp_acc = 0;
  int          exp_miss = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) sets[i].delete();
    exp_acc  = 0;
    exp_miss = 0;
  endtask

  // Evict the least recently used line if the set is full, then bring a line in.
  task automatic model_miss(input logic [31:0] a);
    int          s;
    line_t       v;
    line_t       n;
    logic [31:0] wa;
    s = int'(a[7:4]);
    if (sets[s].size() == 2) begin
      v = sets[s].pop_back();
      if (v.dirty) begin
        for (int i = 0; i < 4; i++) begin
          wa = {v.tag, a[7:4], 2'(i), 2'b00};
          exp_log.push_back(log_t'({1'b1, wa, v.data[i]}));
          exp_mem[wa] = v.data[i];
        end
      end
    end
    n.tag   = a[31:8];
    n.dirty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wa = {a[31:8], a[7:4], 2'(i), 2'b00};
      n.data[i] = mem_rd(wa);
      exp_log.push_back(log_t'({1'b0, wa, 32'h0}));
    end
    sets[s].push_front(n);
    exp_miss++;
  endtask

  task automatic check_log(input string tag);
    check({tag, "/log_len"}, dut_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
      check({tag, "/log_we"},   {31'h0, dut_log[i].we}, {31'h0, exp_log[i].we});
      check({tag, "/log_addr"}, dut_log[i].addr, exp_log[i].addr);
      check({tag, "/log_data"}, dut_log[i].data, exp_log[i].data);
    end
  endtask

  // Hold cs until stall drops; returns load data and cycles cs was held.
  task automatic cpu_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int cycles);
    cs = 1'b1; we = w; addr = a; din = d;
    cycles = 0;
    rd = 32'h0;
    forever begin
      #1;
      cycles++;
      if (!stall) begin
        rd = dout;
        break;
      end
      if (cycles > 300) begin
        check("stall_budget", {31'h0, stall}, 32'h0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input string tag);
    int          s;
    int          pos;
    int          lat;
    int          exp_lat;
    line_t       ln;
    logic [31:0] rd;
    s   = int'(a[7:4]);
    pos = -1;
    exp_log.delete();
    for (int i = 0; i < sets[s].size(); i++)
      if (sets[s][i].tag == a[31:8]) pos = i;
    if (pos >= 0) begin
      ln = sets[s][pos];
      sets[s].delete(pos);
      sets[s].push_front(ln);
    end else begin
      model_miss(a);
    end
    ln = sets[s][0];
    if (w) begin
      ln.data[a[3:2]] = d;
      ln.dirty        = 1'b1;
      sets[s][0]      = ln;
    end
    exp_acc++;
    exp_lat = (pos >= 0) ? 1 : 2 + exp_log.size() * (ram_wait + 1);
    dut_log.delete();
    cpu_access(w, a, d, rd, lat);
    check({tag, "/latency"}, lat, exp_lat);
    if (!w) check({tag, "/data"}, rd, ln.data[a[3:2]]);
    check_log(tag);
    check({tag, "/acc"},  acc_count,  exp_acc);
    check({tag, "/miss"}, miss_count, exp_miss);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic        rw;
    cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    ram_ack = 1'b0; ram_dout = '0; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ram_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      exp_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    repeat (3) @(negedge clk);
    check("rst/ram_cs", {31'h0, ram_cs}, 32'h0);
    check("rst/ram_addr", ram_addr, 32'h0);
    check("rst/stall", {31'h0, stall}, 32'h0);
    check("rst/dout", dout, 32'h0);
    check("rst/acc", acc_count, 32'h0);
    check("rst/miss", miss_count, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then hit in the same line.
    model_access(1'b0, 32'h100, 32'h0, "cold");
    check("cold/acc_abs", acc_count, 32'd1);
    model_access(1'b0, 32'h104, 32'h0, "hit");

    // Same-set conflicts and LRU replacement.
    model_access(1'b0, 32'h1100, 32'h0, "way1");
    model_access(1'b0, 32'h100,  32'h0, "touch");
    model_access(1'b0, 32'h2100, 32'h0, "evict");
    model_access(1'b0, 32'h108,  32'h0, "kept");
    model_access(1'b0, 32'h1100, 32'h0, "gone");

    // Dirty line write-back.
    model_access(1'b1, 32'h100,  32'h0000DEAD, "store");
    model_access(1'b0, 32'h3100, 32'h0, "wb_a");
    model_access(1'b0, 32'h4100, 32'h0, "wb_b");
    model_access(1'b0, 32'h100,  32'h0, "reload");

    // Slow RAM: three wait cycles per word.
    ram_wait = 3;
    model_access(1'b1, 32'h204,  32'h12345678, "slow_st");
    model_access(1'b0, 32'h1204, 32'h0, "slow_a");
    model_access(1'b0, 32'h2204, 32'h0, "slow_b");
    model_access(1'b0, 32'h204,  32'h0, "slow_rd");
    ram_wait = 0;

    // CPU drops cs mid-refill: the fill completes but is not an access.
    exp_log.delete();
    dut_log.delete();
    model_miss(32'h0F0);
    cs = 1'b1; we = 1'b0; addr = 32'h0F0;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 50 && ram_cs; i++) @(negedge clk);
    check("abort/ram_idle", {31'h0, ram_cs}, 32'h0);
    @(negedge clk);
    check_log("abort");
    check("abort/acc", acc_count, exp_acc);
    check("abort/miss", miss_count, exp_miss);
    model_access(1'b0, 32'h0F4, 32'h0, "abort_hit");

    // Reset while the third fill word is outstanding.
    dut_log.delete();
    cs = 1'b1; we = 1'b0; addr = 32'h300;
    for (int i = 0; i < 40 && dut_log.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("rstfill/word2_addr", ram_addr, 32'h308);
    rst_n = 1'b0;
    #1;
    check("rstfill/ram_cs", {31'h0, ram_cs}, 32'h0);
    check("rstfill/stall", {31'h0, stall}, 32'h1);
    check("rstfill/miss", miss_count, 32'h0);
    cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    model_access(1'b0, 32'h300, 32'h0, "rstfill_re");

    // Random traffic over a few conflicting tags.
    for (int n = 0; n < 150; n++) begin
      if (n % 25 == 0) ram_wait = $urandom_range(0, 2);
      ra = {24'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
      rw = 1'($urandom_range(0, 1));
      model_access(rw, ra, $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
